// File: rtl/l2_arbiter.sv
// l2_arbiter: shares the single upstream L2 port between the L1 I-cache (read-only) and the
// L1 D-cache (read/write). One requester is granted per transaction. Its op, address and
// write data are latched at grant time. The L2 port is driven from those latched values
// until l2_resp, and resp/rdata are then returned to the granted requester.
//
// Build option: define ARBITER_ROUND_ROBIN_EN to alternate grants on simultaneous I/D
// requests. Without it, the D-cache always wins ties.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   i_read, i_address                I-cache line read request
//   i_rdata, i_resp                  line data / completion to I-cache
//   d_read, d_write, d_address,
//   d_wdata                          D-cache line read/write request
//   d_rdata, d_resp                  line data / completion to D-cache
//   l2_read, l2_write, l2_address,
//   l2_wdata                         request to L2 (from latched values)
//   l2_rdata, l2_resp                data / completion from L2
module l2_arbiter #(
   parameter int unsigned s_offset = 5,
   parameter int unsigned s_line   = 8 * 2**s_offset
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [31:0]       i_address,
   output logic [s_line-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [31:0]       d_address,
   input  logic [s_line-1:0] d_wdata,
   output logic [s_line-1:0] d_rdata,
   output logic              d_resp,
   output logic              l2_read,
   output logic              l2_write,
   output logic [31:0]       l2_address,
   output logic [s_line-1:0] l2_wdata,
   input  logic [s_line-1:0] l2_rdata,
   input  logic              l2_resp
);

   typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

   state_e              state_q, state_d;
   logic                op_write_q, op_write_d;
   logic [31:0]         addr_q, addr_d;
   logic [s_line-1:0]   wdata_q, wdata_d;
   logic                last_grant_q, last_grant_d;  // 0 = I-cache, 1 = D-cache
   logic                i_req, d_req, grant_d;

   always_comb begin
      i_req = i_read;
      // A simultaneous read and write from the D-cache is treated as a write.
      d_req = d_read | d_write;
`ifdef ARBITER_ROUND_ROBIN_EN
      // On a tie, D wins only if I was granted last.
      grant_d = d_req && (!i_req || !last_grant_q);
`else
      grant_d = d_req;
`endif

      state_d      = state_q;
      op_write_d   = op_write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      last_grant_d = last_grant_q;

      case (state_q)
         StIdle: begin
            if (grant_d) begin
               state_d      = StServeD;
               op_write_d   = d_write;
               addr_d       = d_address;
               wdata_d      = d_wdata;
               last_grant_d = 1'b1;
            end else if (i_req) begin
               state_d      = StServeI;
               op_write_d   = 1'b0;
               addr_d       = i_address;
               last_grant_d = 1'b0;
            end
         end
         StServeI, StServeD: begin
            if (l2_resp) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         op_write_q   <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         last_grant_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_write_q   <= op_write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         last_grant_q <= last_grant_d;
      end
   end

   // L2 request comes only from latched state; live requester inputs are ignored while serving.
   assign l2_read    = (state_q != StIdle) && !op_write_q;
   assign l2_write   = (state_q != StIdle) && op_write_q;
   assign l2_address = addr_q;
   assign l2_wdata   = wdata_q;

   // A reset in the same cycle as l2_resp drops the transaction, so no resp is issued.
   assign i_resp  = (state_q == StServeI) && l2_resp && !rst;
   assign d_resp  = (state_q == StServeD) && l2_resp && !rst;
   assign i_rdata = l2_rdata;
   assign d_rdata = l2_rdata;

`ifndef SYNTHESIS
   a_no_d_read_write: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));
`endif

endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: self-checking bench for l2_arbiter. A transaction-level reference model
// (busy flag, owner, op, latched address/data, last grant) predicts the DUT outputs every
// cycle. Directed scenarios pin exact literal values; a randomized phase follows.
module tb_l2_arbiter;

   localparam int unsigned SLine = 256;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             i_read = 1'b0;
   logic [31:0]      i_address = '0;
   logic [SLine-1:0] i_rdata;
   logic             i_resp;
   logic             d_read = 1'b0;
   logic             d_write = 1'b0;
   logic [31:0]      d_address = '0;
   logic [SLine-1:0] d_wdata = '0;
   logic [SLine-1:0] d_rdata;
   logic             d_resp;
   logic             l2_read;
   logic             l2_write;
   logic [31:0]      l2_address;
   logic [SLine-1:0] l2_wdata;
   logic [SLine-1:0] l2_rdata = '0;
   logic             l2_resp = 1'b0;

   l2_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .i_read     (i_read),
      .i_address  (i_address),
      .i_rdata    (i_rdata),
      .i_resp     (i_resp),
      .d_read     (d_read),
      .d_write    (d_write),
      .d_address  (d_address),
      .d_wdata    (d_wdata),
      .d_rdata    (d_rdata),
      .d_resp     (d_resp),
      .l2_read    (l2_read),
      .l2_write   (l2_write),
      .l2_address (l2_address),
      .l2_wdata   (l2_wdata),
      .l2_rdata   (l2_rdata),
      .l2_resp    (l2_resp)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [SLine-1:0] act,
                        input logic [SLine-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [SLine-1:0] rand_line();
      logic [SLine-1:0] v;
      for (int k = 0; k < SLine / 32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   // ---------------- reference model ----------------
   // One outstanding transaction at most; owner 0 = I, 1 = D.
   logic             m_busy = 1'b0;
   logic             m_owner = 1'b0;
   logic             m_wr = 1'b0;
   logic [31:0]      m_addr = '0;
   logic [SLine-1:0] m_wdata = '0;
   logic             m_last = 1'b0;
   logic             chk_en = 1'b0;

   function automatic logic pick_d(input logic want_i, input logic want_d, input logic last);
      if (!want_d) return 1'b0;
      if (!want_i) return 1'b1;
`ifdef ARBITER_ROUND_ROBIN_EN
      return !last;  // tie: whoever was not granted last
`else
      return 1'b1;   // tie: D-cache has priority
`endif
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_busy  <= 1'b0;
         m_wr    <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
         m_last  <= 1'b0;
      end else if (m_busy) begin
         if (l2_resp) m_busy <= 1'b0;
      end else if (i_read || d_read || d_write) begin
         m_busy <= 1'b1;
         if (pick_d(i_read, d_read || d_write, m_last)) begin
            m_owner <= 1'b1;
            m_wr    <= d_write;
            m_addr  <= d_address;
            m_wdata <= d_wdata;
            m_last  <= 1'b1;
         end else begin
            m_owner <= 1'b0;
            m_wr    <= 1'b0;
            m_addr  <= i_address;
            m_last  <= 1'b0;
         end
      end
   end

   logic i_resp_seen = 1'b0;
   logic d_resp_seen = 1'b0;

   always @(negedge clk) begin
      logic exp_ir, exp_dr;
      i_resp_seen = i_resp;
      d_resp_seen = d_resp;
      if (chk_en) begin
         exp_ir = m_busy && !m_owner && l2_resp && !rst;
         exp_dr = m_busy && m_owner && l2_resp && !rst;
         check("l2_read", l2_read, m_busy && !m_wr);
         check("l2_write", l2_write, m_busy && m_wr);
         check("l2_address", l2_address, m_addr);
         check("l2_wdata", l2_wdata, m_wdata);
         check("i_resp", i_resp, exp_ir);
         check("d_resp", d_resp, exp_dr);
         if (exp_ir) check("i_rdata", i_rdata, l2_rdata);
         if (exp_dr) check("d_rdata", d_rdata, l2_rdata);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      logic [SLine-1:0] a5, wd0;
      logic             i_act, d_act, op;
      a5  = {32{8'hA5}};
      wd0 = {8{32'h1234_5678}};

      // Reset then idle
      tick();
      chk_en = 1'b1;
      tick();
      settle();
      check("rst_l2_read", l2_read, 1'b0);
      check("rst_l2_write", l2_write, 1'b0);
      check("rst_i_resp", i_resp, 1'b0);
      check("rst_d_resp", d_resp, 1'b0);
      check("rst_l2_address", l2_address, 32'h0);
      check("rst_l2_wdata", l2_wdata, '0);
      rst = 1'b0;

      // I read alone, L2 answers 5 cycles after the grant
      i_read = 1'b1; i_address = 32'h0000_0040;
      tick(); settle();
      check("ird_l2_read", l2_read, 1'b1);
      check("ird_l2_address", l2_address, 32'h40);
      repeat (4) tick();
      l2_resp = 1'b1; l2_rdata = a5;
      settle();
      check("ird_i_resp", i_resp, 1'b1);
      check("ird_i_rdata", i_rdata, a5);
      check("ird_d_resp", d_resp, 1'b0);
      tick();
      i_read = 1'b0; l2_resp = 1'b0;
      settle();
      check("ird_i_resp_pulse", i_resp, 1'b0);
      check("ird_idle", l2_read, 1'b0);

      // D write alone; d_wdata changes mid-transaction
      d_write = 1'b1; d_address = 32'h0000_0D80; d_wdata = wd0;
      tick();
      d_wdata = ~wd0;
      settle();
      check("dwr_l2_write", l2_write, 1'b1);
      check("dwr_l2_read", l2_read, 1'b0);
      check("dwr_l2_address", l2_address, 32'h0D80);
      check("dwr_l2_wdata", l2_wdata, wd0);
      tick(); tick();
      l2_resp = 1'b1; l2_rdata = rand_line();
      settle();
      check("dwr_d_resp", d_resp, 1'b1);
      check("dwr_i_resp", i_resp, 1'b0);
      tick();
      d_write = 1'b0; l2_resp = 1'b0;
      tick();

`ifndef ARBITER_ROUND_ROBIN_EN
      // Tie with fixed priority: D first, I after one idle cycle
      i_read = 1'b1; i_address = 32'h0000_1000;
      d_read = 1'b1; d_address = 32'h0000_2000;
      tick(); settle();
      check("tie_first_addr", l2_address, 32'h2000);
      check("tie_first_read", l2_read, 1'b1);
      l2_resp = 1'b1;
      settle();
      check("tie_d_resp", d_resp, 1'b1);
      tick();
      d_read = 1'b0; l2_resp = 1'b0;
      settle();
      check("tie_idle_gap", l2_read, 1'b0);
      tick(); settle();
      check("tie_second_addr", l2_address, 32'h1000);
      check("tie_second_read", l2_read, 1'b1);
      l2_resp = 1'b1;
      settle();
      check("tie_i_resp", i_resp, 1'b1);
      tick();
      i_read = 1'b0; l2_resp = 1'b0;
      tick();
`else
      // Round-robin ties starting from last_grant = I: expect D, I, D, I
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int r = 0; r < 4; r++) begin
         i_read = 1'b1; i_address = 32'h0000_1000;
         d_read = 1'b1; d_address = 32'h0000_2000;
         tick(); settle();
         check("rr_grant_addr", l2_address, (r % 2 == 0) ? 32'h2000 : 32'h1000);
         l2_resp = 1'b1;
         tick();
         i_read = 1'b0; d_read = 1'b0; l2_resp = 1'b0;
         tick();
      end
`endif

      // Reset two cycles into SERVE_D, followed by a late l2_resp
      d_read = 1'b1; d_address = 32'h0000_3000;
      tick(); tick();
      rst = 1'b1;
      settle();
      check("rmid_d_resp", d_resp, 1'b0);
      tick();
      rst = 1'b0; d_read = 1'b0; l2_resp = 1'b1;
      settle();
      check("rmid_l2_read", l2_read, 1'b0);
      check("rmid_late_d_resp", d_resp, 1'b0);
      check("rmid_late_i_resp", i_resp, 1'b0);
      tick();
      l2_resp = 1'b0;
      settle();
      check("rmid_still_idle", l2_read, 1'b0);

      // Randomized traffic obeying the requester handshake
      i_act = 1'b0; d_act = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         rst = ($urandom_range(0, 199) == 0);
         if (rst) begin
            i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
            i_act = 1'b0; d_act = 1'b0;
         end else begin
            if (i_act) begin
               if (i_resp_seen) begin i_read = 1'b0; i_act = 1'b0; end
            end else if ($urandom_range(0, 2) == 0) begin
               i_read = 1'b1; i_address = $urandom; i_act = 1'b1;
            end
            if (d_act) begin
               if (d_resp_seen) begin
                  d_read = 1'b0; d_write = 1'b0; d_act = 1'b0;
               end else begin
                  d_wdata = rand_line();
               end
            end else if ($urandom_range(0, 2) == 0) begin
               op = 1'($urandom_range(0, 1));
               d_read = !op; d_write = op;
               d_address = $urandom; d_wdata = rand_line(); d_act = 1'b1;
            end
         end
         l2_resp  = ($urandom_range(0, 3) == 0);
         l2_rdata = rand_line();
      end

      tick();
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; l2_resp = 1'b0; rst = 1'b0;
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
